// File: rtl/spi_slave_rx.sv
// Receive-side SPI endpoint: synchronizes sclk/cs/mosi into the system clock domain,
// reassembles CS-framed words and hands them off through a single-word valid/ready buffer.

module spi_slave_rx #(
    parameter int DATA_WIDTH = 12,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    // Index 0/1 are the synchronizer stages, index 2 is the history flop for edge detection.
    logic [2:0] sclk_pipe;
    logic [2:0] cs_pipe;
    logic [2:0] mosi_pipe;

    logic [1:0] fill_cnt;
    logic       armed;

    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic mosi_bit;

    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;

    logic capture;
    logic complete;
    logic abort;
    logic clear_cnt;
    logic word_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe <= 3'b000;
            cs_pipe   <= 3'b111;
            mosi_pipe <= 3'b000;
        end else begin
            sclk_pipe <= {sclk_pipe[1:0], sclk};
            cs_pipe   <= {cs_pipe[1:0], cs};
            mosi_pipe <= {mosi_pipe[1:0], mosi};
        end
    end

    // Only accept a cs fall once cs has been seen high with the pipeline holding real pin
    // values, so a frame already in progress at reset release is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (fill_cnt != 2'd3) begin
                fill_cnt <= fill_cnt + 2'd1;
            end
            if (fill_cnt == 2'd3 && cs_pipe[1]) begin
                armed <= 1'b1;
            end
        end
    end

    assign sclk_fall = sclk_pipe[2] & ~sclk_pipe[1];
    assign cs_fall   = armed & cs_pipe[2] & ~cs_pipe[1];
    assign cs_rise   = ~cs_pipe[2] & cs_pipe[1];
    assign mosi_bit  = mosi_pipe[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (cs_rise) begin
                    next_state = IDLE;
                end else if (sclk_fall) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    next_state = IDLE;
                end else if (sclk_fall && bit_cnt == LAST_BIT) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A cs rise coinciding with an sclk fall wins: the bit is not captured.
    always_comb begin
        capture   = (state == SHIFT) && sclk_fall && !cs_rise;
        complete  = capture && (bit_cnt == LAST_BIT);
        abort     = ((state == SETUP) || (state == SHIFT)) && cs_rise;
        clear_cnt = (state == IDLE) && cs_fall;
        busy      = (state != IDLE);
    end

    always_comb begin
        if (LSB_FIRST) begin
            bit_idx = bit_cnt;
        end else begin
            bit_idx = LAST_BIT - bit_cnt;
        end
        shift_next = shift_reg;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_idx == CNT_W'(i)) begin
                shift_next[i] = mosi_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (clear_cnt) begin
            bit_cnt <= '0;
        end else if (capture) begin
            bit_cnt   <= bit_cnt + CNT_W'(1);
            shift_reg <= shift_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            word_done <= complete;
            frame_err <= abort;
        end
    end

    // Single-word buffer: a new word replaces the old one only if the old one is
    // empty or being consumed in the same cycle; otherwise the new word is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (word_done) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= shift_reg;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Scoreboard bench for spi_slave_rx: an LSB-first and an MSB-first instance share the
// serial lines; expected words are queued at stimulus time and popped on each handshake.

module tb_spi_slave_rx;

    localparam int PH = 6;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic        dout_ready;
    logic [11:0] dout;
    logic        dout_valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    logic        dout_ready_m;
    logic [11:0] dout_m;
    logic        dout_valid_m;
    logic        busy_m;
    logic        frame_err_m;
    logic        overrun_m;

    logic [11:0] exp_q[$];
    logic [11:0] exp_m_q[$];
    logic [11:0] exp_word;

    int total;
    int bad;
    int fe_cnt;
    int ov_cnt;
    int ov_m_cnt;

    spi_slave_rx #(.DATA_WIDTH(12), .LSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    spi_slave_rx #(.DATA_WIDTH(12), .LSB_FIRST(1'b0)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .dout       (dout_m),
        .dout_valid (dout_valid_m),
        .dout_ready (dout_ready_m),
        .busy       (busy_m),
        .frame_err  (frame_err_m),
        .overrun    (overrun_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] rev12(input logic [11:0] w);
        logic [11:0] r;
        for (int i = 0; i < 12; i++) begin
            r[i] = w[11-i];
        end
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sclk pulse per iteration; the first fall is the setup edge, then bit k-1 is presented at rise k.
    task automatic apply_stimulus(input logic [11:0] word, input bit ready_pulse);
        cs = 1'b0;
        wait_clks(PH);
        for (int k = 0; k <= 12; k++) begin
            sclk = 1'b1;
            if (k > 0) mosi = word[k-1];
            wait_clks(PH);
            if (k == 6) check_output("busy_mid_frame", {31'd0, busy}, 32'd1);
            sclk = 1'b0;
            if (k == 12 && ready_pulse) begin
                wait_clks(3);
                dout_ready = 1'b1;
                wait_clks(1);
                dout_ready = 1'b0;
                wait_clks(PH - 4);
            end else begin
                wait_clks(PH);
            end
        end
        cs = 1'b1;
        wait_clks(PH);
    endtask

    task automatic partial_frame(input int pulses, input bit raise_cs);
        cs = 1'b0;
        wait_clks(PH);
        for (int k = 0; k < pulses; k++) begin
            sclk = 1'b1;
            mosi = k[0];
            wait_clks(PH);
            sclk = 1'b0;
            wait_clks(PH);
        end
        if (raise_cs) begin
            cs = 1'b1;
            wait_clks(2 * PH);
        end
    endtask

    // Monitor: pop and compare on every handshake, count error pulse cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid && dout_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL lsb_word: got %0h, want nothing (queue empty)", dout);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (dout !== exp_word) begin
                        bad++;
                        $display("[TB] FAIL lsb_word: got %0h, want %0h", dout, exp_word);
                    end
                end
            end
            if (dout_valid_m && dout_ready_m) begin
                total++;
                if (exp_m_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL msb_word: got %0h, want nothing (queue empty)", dout_m);
                end else begin
                    exp_word = exp_m_q.pop_front();
                    if (dout_m !== exp_word) begin
                        bad++;
                        $display("[TB] FAIL msb_word: got %0h, want %0h", dout_m, exp_word);
                    end
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (overrun_m) ov_m_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        ov_m_cnt = 0;
        rst = 1'b1;
        sclk = 1'b0;
        cs = 1'b1;
        mosi = 1'b0;
        dout_ready = 1'b0;
        dout_ready_m = 1'b1;
        wait_clks(5);
        check_output("rst_dout", {20'd0, dout}, 32'd0);
        check_output("rst_valid", {31'd0, dout_valid}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_output("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        wait_clks(8);

        $display("[TB] basic frame");
        dout_ready = 1'b1;
        exp_q.push_back(12'hA5C);
        exp_m_q.push_back(12'h3A5);
        apply_stimulus(12'hA5C, 1'b0);
        wait_clks(PH);
        check_output("busy_after_frame", {31'd0, busy}, 32'd0);
        check_output("basic_no_frame_err", fe_cnt, 0);
        check_output("basic_no_overrun", ov_cnt, 0);

        $display("[TB] msb-first word 001");
        exp_q.push_back(12'h001);
        exp_m_q.push_back(12'h800);
        apply_stimulus(12'h001, 1'b0);
        wait_clks(PH);

        $display("[TB] overrun");
        dout_ready = 1'b0;
        exp_q.push_back(12'h123);
        exp_m_q.push_back(rev12(12'h123));
        apply_stimulus(12'h123, 1'b0);
        exp_m_q.push_back(rev12(12'h456));
        apply_stimulus(12'h456, 1'b0);
        wait_clks(PH);
        check_output("overrun_dout_kept", {20'd0, dout}, 32'h123);
        check_output("overrun_valid", {31'd0, dout_valid}, 32'd1);
        check_output("overrun_pulses", ov_cnt, 1);
        dout_ready = 1'b1;
        wait_clks(2);
        dout_ready = 1'b0;
        check_output("drain_valid_clear", {31'd0, dout_valid}, 32'd0);
        check_output("drain_dout_retained", {20'd0, dout}, 32'h123);

        $display("[TB] simultaneous complete and accept");
        exp_q.push_back(12'h123);
        exp_m_q.push_back(rev12(12'h123));
        apply_stimulus(12'h123, 1'b0);
        exp_q.push_back(12'h456);
        exp_m_q.push_back(rev12(12'h456));
        apply_stimulus(12'h456, 1'b1);
        wait_clks(PH);
        check_output("simul_dout", {20'd0, dout}, 32'h456);
        check_output("simul_valid", {31'd0, dout_valid}, 32'd1);
        check_output("simul_no_overrun", ov_cnt, 1);
        dout_ready = 1'b1;
        wait_clks(2);

        $display("[TB] truncated frame");
        partial_frame(5, 1'b1);
        check_output("trunc_frame_err", fe_cnt, 1);
        check_output("trunc_valid", {31'd0, dout_valid}, 32'd0);
        check_output("trunc_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(12'hFFF);
        exp_m_q.push_back(12'hFFF);
        apply_stimulus(12'hFFF, 1'b0);
        wait_clks(PH);

        $display("[TB] reset mid-frame");
        partial_frame(7, 1'b0);
        rst = 1'b1;
        wait_clks(3);
        check_output("midrst_dout", {20'd0, dout}, 32'd0);
        check_output("midrst_busy", {31'd0, busy}, 32'd0);
        check_output("midrst_valid", {31'd0, dout_valid}, 32'd0);
        rst = 1'b0;
        wait_clks(PH);
        for (int k = 0; k < 8; k++) begin
            sclk = 1'b1;
            wait_clks(PH);
            sclk = 1'b0;
            wait_clks(PH);
        end
        check_output("postrst_busy", {31'd0, busy}, 32'd0);
        check_output("postrst_valid", {31'd0, dout_valid}, 32'd0);
        cs = 1'b1;
        wait_clks(PH);
        exp_q.push_back(12'h3C3);
        exp_m_q.push_back(12'hC3C);
        apply_stimulus(12'h3C3, 1'b0);
        wait_clks(20);

        check_output("final_frame_err", fe_cnt, 1);
        check_output("final_overrun", ov_cnt, 1);
        check_output("msb_no_overrun", ov_m_cnt, 0);
        check_output("lsb_queue_empty", exp_q.size(), 0);
        check_output("msb_queue_empty", exp_m_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
